// File: rtl/game_sequencer.sv
// Runner game sequencer: frame tick and timer, game state machine with speed
// acceleration, pause toggling and crash-restart hold-off.
module game_sequencer #(
    parameter int CLK_PER_FRAME = 555_555,
    parameter int FPS           = 60,
    parameter int SPEED_W       = 15,
    parameter int SPEED_INIT    = 6144,
    parameter int MAX_SPEED     = 13312,
    parameter int ACCELERATION  = 1,
    parameter int CLEAR_TIME    = 180,
    parameter int RESTART_DELAY = 45
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    jumping,
    input  logic                    pause_req,
    input  logic                    crashed,
    output logic                    update,
    output logic [$clog2(FPS)-1:0]  timer,
    output logic [1:0]              state,
    output logic [SPEED_W-1:0]      speed,
    output logic                    has_obstacles,
    output logic                    game_rst
);

    localparam int CNT_W = $clog2(CLK_PER_FRAME);
    localparam int TMR_W = $clog2(FPS);
    localparam int CLR_W = (CLEAR_TIME > 0) ? $clog2(CLEAR_TIME + 1) : 1;
    localparam int CRS_W = (RESTART_DELAY > 0) ? $clog2(RESTART_DELAY + 1) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_PER_FRAME - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(FPS - 1);
    localparam logic [SPEED_W-1:0] SPD_INIT = SPEED_W'(SPEED_INIT);
    localparam logic [SPEED_W:0]   SPD_MAX  = (SPEED_W + 1)'(MAX_SPEED);
    localparam logic [SPEED_W:0]   SPD_ACC  = (SPEED_W + 1)'(ACCELERATION);
    localparam logic [CLR_W-1:0]   CLR_LAST = CLR_W'(CLEAR_TIME);
    localparam logic [CRS_W-1:0]   CRS_LAST = CRS_W'(RESTART_DELAY);

    if (SPEED_INIT > MAX_SPEED || MAX_SPEED >= (1 << SPEED_W) ||
        CLK_PER_FRAME < 2 || FPS < 2) begin : g_param_check
        $fatal(1, "game_sequencer: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_CRASH = 2'd3
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [CLR_W-1:0] clear_cnt;
    logic [CLR_W-1:0] clear_next;
    logic [CRS_W-1:0] crash_cnt;
    logic             pause_q;
    logic             pause_pend;
    logic             pause_rise;

    // Sum is formed one bit wider so an overflow past the ceiling still clamps.
    function automatic logic [SPEED_W-1:0] accel_sat(input logic [SPEED_W-1:0] s);
        logic [SPEED_W:0] sum;
        sum = {1'b0, s} + SPD_ACC;
        return (sum > SPD_MAX) ? SPD_MAX[SPEED_W-1:0] : sum[SPEED_W-1:0];
    endfunction

    assign pause_rise = pause_req & ~pause_q;
    assign clear_next = (clear_cnt == CLR_LAST) ? clear_cnt : clear_cnt + 1'b1;
    assign state      = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            update <= 1'b0;
            timer  <= '0;
        end else begin
            update <= (cnt == CNT_LAST);
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                timer <= (timer == TMR_LAST) ? '0 : timer + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st            <= S_WAIT;
            speed         <= '0;
            has_obstacles <= 1'b0;
            game_rst      <= 1'b0;
            clear_cnt     <= '0;
            crash_cnt     <= '0;
            pause_q       <= 1'b0;
            pause_pend    <= 1'b0;
        end else begin
            pause_q  <= pause_req;
            game_rst <= 1'b0;
            // A request is consumed at each frame; an edge on the frame cycle itself carries over.
            if (update) begin
                pause_pend <= pause_rise;
            end else if (pause_rise) begin
                pause_pend <= 1'b1;
            end

            case (st)
                S_WAIT: begin
                    if (update && jumping) begin
                        st            <= S_RUN;
                        speed         <= SPD_INIT;
                        clear_cnt     <= '0;
                        has_obstacles <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (crashed) begin
                        st        <= S_CRASH;
                        crash_cnt <= '0;
                    end else if (update) begin
                        if (pause_pend) begin
                            st <= S_PAUSE;
                        end else begin
                            speed     <= accel_sat(speed);
                            clear_cnt <= clear_next;
                            if (clear_next == CLR_LAST) begin
                                has_obstacles <= 1'b1;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (update && pause_pend) begin
                        st <= S_RUN;
                    end
                end
                S_CRASH: begin
                    pause_pend <= 1'b0;
                    if (update) begin
                        if (jumping && crash_cnt == CRS_LAST) begin
                            st            <= S_RUN;
                            speed         <= SPD_INIT;
                            clear_cnt     <= '0;
                            has_obstacles <= 1'b0;
                            crash_cnt     <= '0;
                            game_rst      <= 1'b1;
                        end else if (crash_cnt != CRS_LAST) begin
                            crash_cnt <= crash_cnt + 1'b1;
                        end
                    end
                end
                default: st <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer using a small frame (4 clocks, 3 frames per timer wrap).
`timescale 1ns/1ps
module tb_game_sequencer;

    localparam int SW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          jumping = 1'b0;
    logic          pause_req = 1'b0;
    logic          crashed = 1'b0;
    logic          update;
    logic [1:0]    timer;
    logic [1:0]    state;
    logic [SW-1:0] speed;
    logic          has_obstacles;
    logic          game_rst;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]    st;
        logic [SW-1:0] spd;
        logic          obs;
        logic          grst;
    } snap_t;

    typedef struct packed {
        logic       upd;
        logic [1:0] tmr;
        logic [1:0] st;
    } tk_t;

    snap_t sb[$];
    tk_t   tq[$];

    always #5 clk = ~clk;

    game_sequencer #(
        .CLK_PER_FRAME(4),
        .FPS(3),
        .SPEED_W(SW),
        .SPEED_INIT(10),
        .MAX_SPEED(12),
        .ACCELERATION(1),
        .CLEAR_TIME(2),
        .RESTART_DELAY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .jumping(jumping),
        .pause_req(pause_req),
        .crashed(crashed),
        .update(update),
        .timer(timer),
        .state(state),
        .speed(speed),
        .has_obstacles(has_obstacles),
        .game_rst(game_rst)
    );

    function automatic snap_t mk(input logic [1:0] st, input logic [SW-1:0] spd,
                                 input logic obs, input logic grst);
        snap_t s;
        s.st = st; s.spd = spd; s.obs = obs; s.grst = grst;
        return s;
    endfunction

    function automatic snap_t now_snap();
        return mk(state, speed, has_obstacles, game_rst);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_update(output bit ok);
        int n;
        n = 0;
        while (update !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        ok = (update === 1'b1);
    endtask

    // Waits for the frame strobe, then steps past the edge that closes it.
    task automatic frame(output bit ok);
        wait_update(ok);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; jumping = 1'b0; pause_req = 1'b0; crashed = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL reset_update: got %0d want 0", update); end
        checks++; if (timer !== 2'd0) begin errors++; $display("FAIL reset_timer: got %0d want 0", timer); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (speed !== '0) begin errors++; $display("FAIL reset_speed: got %0d want 0", speed); end
        checks++; if (has_obstacles !== 1'b0) begin errors++; $display("FAIL reset_obs: got %0d want 0", has_obstacles); end
        checks++; if (game_rst !== 1'b0) begin errors++; $display("FAIL reset_game_rst: got %0d want 0", game_rst); end
    endtask

    task automatic test_tick();
        tk_t t;
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            t.upd = (c % 4 == 0);
            t.tmr = 2'((c / 4) % 3);
            t.st  = 2'd0;
            tq.push_back(t);
        end
        for (int c = 1; c <= 16; c++) begin
            tick();
            t = tq.pop_front();
            checks++;
            if ({update, timer, state} !== t) begin
                errors++;
                $display("FAIL tick_cycle%0d: got update=%0d timer=%0d state=%0d, want update=%0d timer=%0d state=%0d",
                         c, update, timer, state, t.upd, t.tmr, t.st);
            end
        end
    endtask

    task automatic test_start_accel();
        snap_t exp_tab[5];
        snap_t e;
        bit ok;
        exp_tab[0] = mk(2'd1, 15'd10, 1'b0, 1'b0);
        exp_tab[1] = mk(2'd1, 15'd11, 1'b0, 1'b0);
        exp_tab[2] = mk(2'd1, 15'd12, 1'b1, 1'b0);
        exp_tab[3] = mk(2'd1, 15'd12, 1'b1, 1'b0);
        exp_tab[4] = mk(2'd1, 15'd12, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            jumping = (i == 0);
            sb.push_back(exp_tab[i]);
            frame(ok);
            jumping = 1'b0;
            e = sb.pop_front();
            checks++;
            if (!ok || now_snap() !== e) begin
                errors++;
                $display("FAIL accel_frame%0d: got st=%0d spd=%0d obs=%0d grst=%0d upd_seen=%0d, want st=%0d spd=%0d obs=%0d grst=%0d",
                         i, state, speed, has_obstacles, game_rst, ok, e.st, e.spd, e.obs, e.grst);
            end
        end
    endtask

    task automatic test_pause();
        snap_t e;
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin jumping = 1'b1; sb.push_back(mk(2'd1, 15'd10, 1'b0, 1'b0)); end
                1: sb.push_back(mk(2'd1, 15'd11, 1'b0, 1'b0));
                2: begin
                    pause_req = 1'b1; tick(); pause_req = 1'b0; tick();
                    pause_req = 1'b1; tick(); pause_req = 1'b0;
                    sb.push_back(mk(2'd2, 15'd11, 1'b0, 1'b0));
                end
                3: begin
                    pause_req = 1'b1; tick(); pause_req = 1'b0;
                    sb.push_back(mk(2'd1, 15'd11, 1'b0, 1'b0));
                end
                default: sb.push_back(mk(2'd1, 15'd12, 1'b1, 1'b0));
            endcase
            frame(ok);
            jumping = 1'b0;
            e = sb.pop_front();
            checks++;
            if (!ok || now_snap() !== e) begin
                errors++;
                $display("FAIL pause_step%0d: got st=%0d spd=%0d obs=%0d grst=%0d upd_seen=%0d, want st=%0d spd=%0d obs=%0d grst=%0d",
                         i, state, speed, has_obstacles, game_rst, ok, e.st, e.spd, e.obs, e.grst);
            end
        end
    endtask

    task automatic test_crash_restart();
        snap_t e;
        bit ok;
        logic jump_tab[5];
        snap_t exp_tab[5];
        jump_tab = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_tab[0] = mk(2'd1, 15'd10, 1'b0, 1'b0);
        exp_tab[1] = mk(2'd1, 15'd11, 1'b0, 1'b0);
        exp_tab[2] = mk(2'd3, 15'd11, 1'b0, 1'b0);
        exp_tab[3] = mk(2'd3, 15'd11, 1'b0, 1'b0);
        exp_tab[4] = mk(2'd1, 15'd10, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            jumping = jump_tab[i];
            sb.push_back(exp_tab[i]);
            frame(ok);
            jumping = 1'b0;
            e = sb.pop_front();
            checks++;
            if (!ok || now_snap() !== e) begin
                errors++;
                $display("FAIL crash_frame%0d: got st=%0d spd=%0d obs=%0d grst=%0d upd_seen=%0d, want st=%0d spd=%0d obs=%0d grst=%0d",
                         i, state, speed, has_obstacles, game_rst, ok, e.st, e.spd, e.obs, e.grst);
            end
            if (i == 1) begin
                crashed = 1'b1;
                sb.push_back(mk(2'd3, 15'd11, 1'b0, 1'b0));
                tick();
                crashed = 1'b0;
                e = sb.pop_front();
                checks++;
                if (now_snap() !== e) begin
                    errors++;
                    $display("FAIL crash_latency: got st=%0d spd=%0d, want st=%0d spd=%0d", state, speed, e.st, e.spd);
                end
            end
        end
        sb.push_back(mk(2'd1, 15'd10, 1'b0, 1'b0));
        tick();
        e = sb.pop_front();
        checks++;
        if (now_snap() !== e) begin
            errors++;
            $display("FAIL game_rst_one_cycle: got st=%0d spd=%0d grst=%0d, want st=%0d spd=%0d grst=%0d",
                     state, speed, game_rst, e.st, e.spd, e.grst);
        end
    endtask

    task automatic test_priority_reset();
        snap_t e;
        bit ok;
        int n;
        do_reset();
        jumping = 1'b1;
        sb.push_back(mk(2'd1, 15'd10, 1'b0, 1'b0));
        frame(ok);
        jumping = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!ok || now_snap() !== e) begin
            errors++;
            $display("FAIL prio_start: got st=%0d spd=%0d, want st=%0d spd=%0d", state, speed, e.st, e.spd);
        end
        pause_req = 1'b1; tick(); pause_req = 1'b0;
        wait_update(ok);
        crashed = 1'b1;
        sb.push_back(mk(2'd3, 15'd10, 1'b0, 1'b0));
        tick();
        crashed = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!ok || now_snap() !== e) begin
            errors++;
            $display("FAIL crash_over_pause: got st=%0d spd=%0d upd_seen=%0d, want st=%0d spd=%0d", state, speed, ok, e.st, e.spd);
        end
        tick();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({update, timer, state, speed, has_obstacles, game_rst} !== '0) begin
            errors++;
            $display("FAIL async_reset: got update=%0d timer=%0d state=%0d speed=%0d obs=%0d grst=%0d, want all 0",
                     update, timer, state, speed, has_obstacles, game_rst);
        end
        tick();
        rst = 1'b0;
        n = 0;
        while (update !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL first_update_after_reset: got %0d cycles want 4", n);
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_start_accel();
        test_pause();
        test_crash_restart();
        test_priority_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
